// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with input synchroniser, 3-sample mid-bit majority vote,
// parity/framing/break detection and a one-cycle o_valid strobe per frame.
module uart_rx_cfg #(
   parameter int CLK_FREQ    = 250000,
   parameter int BAUD        = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_in,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_busy
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || SYNC_STAGES < 2) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

   state_t               state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [1:0]           smp_q, smp_d;
   logic [DATA_BITS-1:0] shd_q, shd_d, data_q, data_d;
   logic                 par_q, par_d, stop0_q, stop0_d, perr_q, perr_d, ferr_q, ferr_d;
   logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
   logic                 rx_s, maj, dec, first_stop, fe_now, brk_now;

   always_ff @(posedge i_clk) sync_q <= i_rst ? '1 : {sync_q[SYNC_STAGES-2:0], i_in};

   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
   assign dec        = cnt_q == CW'(HALF + 1);
   assign first_stop = (idx_q == '0) ? maj : stop0_q;
   assign fe_now     = ferr_q | ~maj;
   // A break is an all-zero frame whose parity sample and first stop bit are also low
   assign brk_now    = (shd_q == '0) && (PARITY == 0 || !par_q) && !first_stop;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CW'(CPB - 1)) ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      smp_d   = smp_q;
      shd_d   = shd_q;
      par_d   = par_q;
      stop0_d = stop0_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      pe_d    = pe_q;
      fe_d    = fe_q;
      brk_d   = brk_q;
      if (cnt_q == CW'(HALF - 1)) smp_d[0] = rx_s;
      if (cnt_q == CW'(HALF)) smp_d[1] = rx_s;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
               idx_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: if (dec) state_d = maj ? S_IDLE : S_DATA;
         S_DATA: if (dec) begin
            shd_d = {maj, shd_q[DATA_BITS-1:1]};
            idx_d = idx_q + 1'b1;
            if (idx_q == 4'(DATA_BITS - 1)) begin
               idx_d   = '0;
               state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: if (dec) begin
            par_d   = maj;
            perr_d  = (PARITY == 1) ? ~(^shd_q ^ maj) : (^shd_q ^ maj);
            state_d = S_STOP;
         end
         S_STOP: if (dec) begin
            if (idx_q == '0) stop0_d = maj;
            ferr_d = fe_now;
            idx_d  = idx_q + 1'b1;
            if (idx_q == 4'(STOP_BITS - 1)) begin
               valid_d = 1'b1;
               data_d  = shd_q;
               pe_d    = perr_q;
               fe_d    = fe_now;
               brk_d   = brk_now;
               idx_d   = '0;
               state_d = fe_now ? S_WAIT_HIGH : S_IDLE;
            end
         end
         S_WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         smp_q   <= '0;
         shd_q   <= '0;
         par_q   <= 1'b0;
         stop0_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         smp_q   <= smp_d;
         shd_q   <= shd_d;
         par_q   <= par_d;
         stop0_q <= stop0_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         brk_q   <= brk_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = pe_q;
   assign o_frame_err  = fe_q;
   assign o_break      = brk_q;
   assign o_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations (8N1, 8E1, 9O2) driven by a line model;
// expected frames come from the frame-level rules, and are checked on every o_valid.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
   localparam real BT = 260.0;
   logic       i_clk = 1'b0, i_rst = 1'b1;
   logic       ln [3] = '{1'b1, 1'b1, 1'b1};
   logic [7:0] d0, d1;
   logic [8:0] d2;
   logic [8:0] dat [3];
   logic [2:0] vl, pe, fe, bk, by;
   int         nb [3] = '{8, 8, 9};
   int         pm [3] = '{0, 2, 1};
   int         ns [3] = '{1, 1, 2};
   logic [13:0] exq [$];
   logic [13:0] got [$];
   int         errors = 0, checks = 0;

   always #5 i_clk = ~i_clk;

   uart_rx_cfg u0 (.i_clk(i_clk), .i_rst(i_rst), .i_in(ln[0]), .o_data(d0), .o_valid(vl[0]),
      .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(bk[0]), .o_busy(by[0]));
   uart_rx_cfg #(.PARITY(2)) u1 (.i_clk(i_clk), .i_rst(i_rst), .i_in(ln[1]), .o_data(d1),
      .o_valid(vl[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(bk[1]), .o_busy(by[1]));
   uart_rx_cfg #(.DATA_BITS(9), .STOP_BITS(2), .PARITY(1)) u2 (.i_clk(i_clk), .i_rst(i_rst),
      .i_in(ln[2]), .o_data(d2), .o_valid(vl[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
      .o_break(bk[2]), .o_busy(by[2]));

   assign dat[0] = {1'b0, d0};
   assign dat[1] = {1'b0, d1};
   assign dat[2] = d2;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Frame-level expectation: {unit, data, parity_err, frame_err, break}
   function automatic logic [13:0] model(input int u, input logic [8:0] d, input logic p, input logic [1:0] stp);
      logic pe_e, fe_e, bk_e;
      pe_e = (pm[u] == 0) ? 1'b0 : (pm[u] == 1) ? ((^d ^ p) != 1'b1) : ((^d ^ p) != 1'b0);
      fe_e = !stp[0] || (ns[u] == 2 && !stp[1]);
      bk_e = (d == 9'd0) && (pm[u] == 0 || !p) && !stp[0];
      return {u[1:0], d, pe_e, fe_e, bk_e};
   endfunction

   task automatic send(input int u, input logic [8:0] d, input bit pflip, input logic [1:0] stp,
                       input real bt, input int spk, input real hold, input bit push);
      logic [8:0] dm;
      logic p;
      dm = d & 9'((1 << nb[u]) - 1);
      p  = ^dm ^ (pm[u] == 1) ^ pflip;
      if (push) exq.push_back(model(u, dm, p, stp));
      ln[u] = 1'b0;
      #(bt);
      for (int i = 0; i < nb[u]; i++) begin
         ln[u] = dm[i];
         if (i == spk) begin
            #(bt / 2);
            ln[u] = ~dm[i];
            #10;
            ln[u] = dm[i];
            #(bt / 2 - 10);
         end else #(bt);
      end
      if (pm[u] != 0) begin
         ln[u] = p;
         #(bt);
      end
      for (int i = 0; i < ns[u]; i++) begin
         ln[u] = stp[i];
         #(bt);
      end
      #(hold);
      ln[u] = 1'b1;
   endtask

   function automatic real rbt();
      return BT * (0.98 + real'($urandom_range(40)) / 1000.0);
   endfunction

   always @(negedge i_clk) begin
      if (!i_rst) begin
         for (int u = 0; u < 3; u++) begin
            if (vl[u]) begin
               logic [13:0] act;
               act = {2'(u), dat[u], pe[u], fe[u], bk[u]};
               got.push_back(act);
               if (exq.size() == 0) chk("unexpected_valid", act, 14'h3fff);
               else chk("frame", act, exq.pop_front());
            end
         end
      end
   end

   task automatic settle();
      repeat (4) @(negedge i_clk);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge i_clk);
      for (int u = 0; u < 3; u++) chk("reset_state", {dat[u], vl[u], pe[u], fe[u], bk[u], by[u]}, 0);
      i_rst = 1'b0;
      repeat (5) @(negedge i_clk);
      // back-to-back 8N1 frames
      send(0, 9'h0A5, 0, 2'b11, BT, -1, 0.0, 1);
      send(0, 9'h05A, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t1_first", got[got.size()-2], {2'd0, 9'h0A5, 3'b000});
      chk("t1_second", got[got.size()-1], {2'd0, 9'h05A, 3'b000});
      chk("t1_idle", by[0], 0);
      // even parity good / bad
      send(1, 9'h03C, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t2_par_ok", got[got.size()-1], {2'd1, 9'h03C, 3'b000});
      send(1, 9'h03C, 1, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t2_par_bad", got[got.size()-1], {2'd1, 9'h03C, 3'b100});
      // framing error with line held low past the stop bit
      fork
         send(0, 9'h055, 0, 2'b00, BT, -1, 2.0 * BT, 1);
         begin
            #(11.5 * BT);
            chk("t3_wait_high_busy", by[0], 1);
         end
      join
      settle();
      chk("t3_frame_err", got[got.size()-1], {2'd0, 9'h055, 3'b010});
      chk("t3_released", by[0], 0);
      send(0, 9'h081, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t3_clean", got[got.size()-1], {2'd0, 9'h081, 3'b000});
      // start-bit glitch
      n = got.size();
      ln[0] = 1'b0;
      #50;
      ln[0] = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("t4_glitch_busy", by[0], 1);
      repeat (30) @(negedge i_clk);
      chk("t4_glitch_idle", by[0], 0);
      chk("t4_glitch_novalid", got.size(), n);
      send(0, 9'h000, 0, 2'b11, BT, 2, 0.0, 1);
      settle();
      chk("t4_spike", got[got.size()-1], {2'd0, 9'h000, 3'b000});
      // long break
      exq.push_back(model(0, 9'h000, 1'b0, 2'b00));
      ln[0] = 1'b0;
      #(12.0 * BT);
      ln[0] = 1'b1;
      #(BT);
      chk("t5_break", got[got.size()-1], {2'd0, 9'h000, 3'b011});
      send(0, 9'h081, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t5_after", got[got.size()-1], {2'd0, 9'h081, 3'b000});
      // reset mid-frame, late in data bit 3
      n = got.size();
      fork
         send(0, 9'h0F0, 0, 2'b11, BT, -1, 0.0, 0);
         begin
            #(4.8 * BT);
            @(negedge i_clk);
            i_rst = 1'b1;
            @(negedge i_clk);
            i_rst = 1'b0;
            chk("t6_rst_busy", by[0], 0);
         end
      join
      #(BT);
      chk("t6_no_valid", got.size(), n);
      send(0, 9'h00F, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t6_after", got[got.size()-1], {2'd0, 9'h00F, 3'b000});
      send(2, 9'h1AB, 0, 2'b11, BT, -1, 0.0, 1);
      settle();
      chk("t6_9bit", got[got.size()-1], {2'd2, 9'h1AB, 3'b000});
      // randomized frames with +-2% rate error
      for (int u = 0; u < 3; u++) begin
         for (int k = 0; k < 12; k++) begin
            logic [1:0] stp;
            stp = {1'($urandom_range(7) != 0), 1'($urandom_range(7) != 0)};
            send(u, 9'($urandom), $urandom_range(3) == 0, stp, rbt(), -1, 0.0, 1);
            if (!(&stp)) #(BT);
            else #(real'($urandom_range(30)) * 10.0);
         end
         #(2.0 * BT);
      end
      for (int i = 0; i < 3000 && exq.size() != 0; i++) @(negedge i_clk);
      chk("queue_drained", exq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
